// File: rtl/final_logic_arbiter.sv
// final_logic_arbiter: merges two VC FIFO heads onto two destination FIFOs
// with VC0 priority, a fairness override and non-blocking per-destination pause.
module final_logic_arbiter #(
    parameter int data_width = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] data_vc0,
    input  logic [data_width-1:0] data_vc1,
    input  logic                  empty_vc0,
    input  logic                  empty_vc1,
    input  logic                  pause_d0,
    input  logic                  pause_d1,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic                  push_d0,
    output logic                  push_d1,
    output logic [data_width-1:0] data_out_d0,
    output logic [data_width-1:0] data_out_d1,
    output logic [7:0]            cnt_d0,
    output logic [7:0]            cnt_d1,
    output logic                  idle
);
    localparam logic [1:0] st_reset  = 2'd0;
    localparam logic [1:0] st_idle   = 2'd1;
    localparam logic [1:0] st_active = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [2:0]            fair_cnt_q, fair_cnt_d;
    logic                  push_d0_q, push_d0_d, push_d1_q, push_d1_d;
    logic [data_width-1:0] data_out_d0_q, data_out_d0_d, data_out_d1_q, data_out_d1_d;
    logic [7:0]            cnt_d0_q, cnt_d0_d, cnt_d1_q, cnt_d1_d;
    logic                  idle_q, idle_d;
    logic                  run, elig0, elig1, to_d1;
    logic [data_width-1:0] win;

    always_comb begin
        run           = reset && state_q != st_reset;
        elig0         = run && !empty_vc0 && !(data_vc0[data_width-2] ? pause_d1 : pause_d0);
        elig1         = run && !empty_vc1 && !(data_vc1[data_width-2] ? pause_d1 : pause_d0);
        // VC1 wins outright when VC0 cannot go, or once VC0 has had four turns in a row
        pop_vc1       = elig1 && (!elig0 || fair_cnt_q == 3'd4);
        pop_vc0       = elig0 && !pop_vc1;
        win           = pop_vc1 ? data_vc1 : data_vc0;
        to_d1         = win[data_width-2];
        push_d0_d     = (pop_vc0 || pop_vc1) && !to_d1;
        push_d1_d     = (pop_vc0 || pop_vc1) && to_d1;
        data_out_d0_d = !reset ? '0 : push_d0_d ? win : data_out_d0_q;
        data_out_d1_d = !reset ? '0 : push_d1_d ? win : data_out_d1_q;
        cnt_d0_d      = !reset ? '0 : cnt_d0_q + 8'(push_d0_d);
        cnt_d1_d      = !reset ? '0 : cnt_d1_q + 8'(push_d1_d);
        fair_cnt_d    = (!elig1 || pop_vc1) ? 3'd0 : pop_vc0 ? fair_cnt_q + 3'd1 : fair_cnt_q;
        state_d       = !reset ? st_reset :
                        state_q == st_reset ? st_idle :
                        (elig0 || elig1) ? st_active : st_idle;
        idle_d        = reset && state_d == st_idle && empty_vc0 && empty_vc1;
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        fair_cnt_q    <= fair_cnt_d;
        push_d0_q     <= push_d0_d;
        push_d1_q     <= push_d1_d;
        data_out_d0_q <= data_out_d0_d;
        data_out_d1_q <= data_out_d1_d;
        cnt_d0_q      <= cnt_d0_d;
        cnt_d1_q      <= cnt_d1_d;
        idle_q        <= idle_d;
    end

    assign push_d0     = push_d0_q;
    assign push_d1     = push_d1_q;
    assign data_out_d0 = data_out_d0_q;
    assign data_out_d1 = data_out_d1_q;
    assign cnt_d0      = cnt_d0_q;
    assign cnt_d1      = cnt_d1_q;
    assign idle        = idle_q;
endmodule

// File: tb/tb_final_logic_arbiter.sv
// tb_final_logic_arbiter: directed vectors against queue-modelled VC FIFOs.
module tb_final_logic_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] data_vc0, data_vc1;
    logic       empty_vc0, empty_vc1, pause_d0, pause_d1;
    logic       pop_vc0, pop_vc1, push_d0, push_d1, idle;
    logic [5:0] data_out_d0, data_out_d1;
    logic [7:0] cnt_d0, cnt_d1;
    logic [5:0] q0[$], q1[$];
    logic       p0, p1;
    int         vectors = 0, errs = 0;
    bit         exp_g[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    final_logic_arbiter #(.data_width(6)) dut (
        .clk(clk), .reset(reset),
        .data_vc0(data_vc0), .data_vc1(data_vc1),
        .empty_vc0(empty_vc0), .empty_vc1(empty_vc1),
        .pause_d0(pause_d0), .pause_d1(pause_d1),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
        .push_d0(push_d0), .push_d1(push_d1),
        .data_out_d0(data_out_d0), .data_out_d1(data_out_d1),
        .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        empty_vc0 = q0.size() == 0;
        empty_vc1 = q1.size() == 0;
        data_vc0  = empty_vc0 ? 6'd0 : q0[0];
        data_vc1  = empty_vc1 ? 6'd0 : q1[0];
    endtask

    // one clock: sample pops mid-cycle, let the FIFO model act on them, present new heads
    task automatic tick();
        @(negedge clk);
        p0 = pop_vc0;
        p1 = pop_vc1;
        @(posedge clk);
        #1;
        if (p0 && q0.size() > 0) void'(q0.pop_front());
        if (p1 && q1.size() > 0) void'(q1.pop_front());
        drive();
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b0; pause_d0 = 1'b0; pause_d1 = 1'b0;
        q0.push_back(6'b000001);
        q0.push_back(6'b010010);
        q1.push_back(6'b100001);
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_pop0", pop_vc0, 0);
            chk("rst_pop1", pop_vc1, 0);
            chk("rst_push0", push_d0, 0);
            chk("rst_dout0", data_out_d0, 0);
            chk("rst_cnt0", cnt_d0, 0);
            chk("rst_idle", idle, 0);
        end
        q1.delete();
        reset = 1'b1;
        drive();
        #1;
        chk("pop_before_edge", pop_vc0, 0);
        tick();
        chk("first_pop", pop_vc0, 1);
        chk("first_push0", push_d0, 0);
        tick();
        chk("route_push0", push_d0, 1);
        chk("route_dout0", data_out_d0, 6'b000001);
        chk("route_push1_lo", push_d1, 0);
        chk("route_cnt0", cnt_d0, 1);
        tick();
        chk("route_push1", push_d1, 1);
        chk("route_dout1", data_out_d1, 6'b010010);
        chk("route_push0_lo", push_d0, 0);
        chk("route_hold0", data_out_d0, 6'b000001);
        chk("route_cnt1", cnt_d1, 1);
        chk("route_idle_lo", idle, 0);
        tick();
        chk("idle_after", idle, 1);
        chk("idle_push1", push_d1, 0);

        for (int i = 0; i < 12; i++) begin
            q0.push_back(6'(i));
            q1.push_back(6'(6'b100000 + i));
        end
        drive();
        #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("fair_pop0_%0d", i), pop_vc0, !exp_g[i]);
            chk($sformatf("fair_pop1_%0d", i), pop_vc1, exp_g[i]);
            tick();
        end
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 100) begin
            tick();
            n++;
        end
        chk("fair_drain", n < 100, 1);
        chk("fair_cnt0", cnt_d0, 25);
        chk("fair_last", data_out_d0, 6'b101011);
        chk("fair_last_push", push_d0, 1);
        tick();
        chk("fair_idle", idle, 1);
        chk("fair_push_lo", push_d0, 0);

        pause_d0 = 1'b1;
        q0.push_back(6'b000111);
        q1.push_back(6'b110011);
        drive();
        #1;
        chk("hol_pop0", pop_vc0, 0);
        chk("hol_pop1", pop_vc1, 1);
        tick();
        chk("hol_push1", push_d1, 1);
        chk("hol_dout1", data_out_d1, 6'b110011);
        chk("hol_push0", push_d0, 0);
        chk("hol_still", pop_vc0, 0);
        pause_d0 = 1'b0;
        #1;
        chk("hol_resume", pop_vc0, 1);
        tick();
        chk("hol_push0b", push_d0, 1);
        chk("hol_dout0", data_out_d0, 6'b000111);
        chk("hol_cnt0", cnt_d0, 26);
        chk("hol_cnt1", cnt_d1, 2);

        q0.push_back(6'b000101);
        reset = 1'b0;
        drive();
        #1;
        chk("mid_rst_pop", pop_vc0, 0);
        tick();
        chk("mid_rst_push", push_d0, 0);
        chk("mid_rst_dout", data_out_d0, 0);
        chk("mid_rst_cnt0", cnt_d0, 0);
        chk("mid_rst_cnt1", cnt_d1, 0);
        q0.delete();
        reset = 1'b1;
        drive();
        tick();

        for (int i = 0; i < 256; i++) q1.push_back(6'b010101);
        drive();
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 254) chk("wrap_255", cnt_d1, 255);
        end
        chk("wrap_cnt1", cnt_d1, 0);
        chk("wrap_cnt0", cnt_d0, 0);
        chk("wrap_push1", push_d1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/final_logic_arbiter.md
FINAL_LOGIC_ARBITER -- requirements
Module: final_logic_arbiter

Interface
REQ-001 Parameter data_width, default 6, width of every data word.
REQ-002 Word format SHALL be: bit [data_width-1] = VC id (ignored here), bit [data_width-2] = destination (0 = D0, 1 = D1).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 data_vc0  input  data_width  head word of the VC0 FIFO; show-ahead, valid whenever empty_vc0=0.
REQ-006 data_vc1  input  data_width  head word of the VC1 FIFO; show-ahead, valid whenever empty_vc1=0.
REQ-007 empty_vc0, empty_vc1  input  1 each  VC FIFO empty flags.
REQ-008 pause_d0, pause_d1  input  1 each  destination FIFO almost-full flags; asserted with at least 1 free entry of margin.
REQ-009 pop_vc0, pop_vc1  output  1 each  combinational pop strobes to the VC FIFOs.
REQ-010 push_d0, push_d1  output  1 each  registered push strobes to the destination FIFOs.
REQ-011 data_out_d0, data_out_d1  output  data_width each  registered words to the destination FIFOs.
REQ-012 cnt_d0, cnt_d1  output  8 each  registered count of words pushed to each destination.
REQ-013 idle  output  1  registered flag: both VCs empty and no push issued this cycle.

Function
REQ-014 A VC SHALL be eligible when its empty flag is 0, reset is 1, and the pause flag of its head word's destination is 0.
REQ-015 At most one pop SHALL be asserted per cycle; pop_vc0 and pop_vc1 are never high together.
REQ-016 Default priority: VC0 when eligible; otherwise VC1 when eligible; otherwise no pop.
REQ-017 An ineligible VC0 head SHALL NOT block VC1; an eligible VC1 SHALL be popped in the same cycle.
REQ-018 Fairness counter fair_cnt (3 bits) SHALL count consecutive VC0 grants made while VC1 is eligible.
REQ-019 When fair_cnt = 4 and VC1 is eligible, VC1 SHALL be granted over an eligible VC0, and fair_cnt SHALL clear to 0.
REQ-020 fair_cnt SHALL clear on any VC1 grant, and on any cycle with VC1 not eligible.
REQ-021 Latency: a word popped in cycle N SHALL appear on data_out_dX, with push_dX=1, in cycle N+1, where X is the word's destination bit.
REQ-022 The push signal of the other destination SHALL be 0 in cycle N+1; pushes last exactly one cycle per word.
REQ-023 data_out_dX SHALL hold its last value when push_dX=0.
REQ-024 cnt_dX SHALL increment by 1 in the cycle that push_dX is registered high.
REQ-025 cnt_dX SHALL wrap from 255 to 0 without a flag.
REQ-026 Pause asserted in the same cycle as a pop decision SHALL prevent that pop; a push already in flight SHALL complete, relying on the 1-entry margin.
REQ-027 Arbiter state machine: RESET -> IDLE on the first edge with reset=1.
REQ-028 IDLE -> ACTIVE when any VC is eligible; ACTIVE -> IDLE when no VC is eligible.
REQ-029 idle SHALL be 1 only in the IDLE state with both empty flags high.

Reset
REQ-030 While reset=0 at a rising edge, the following SHALL be 0: pop_*, push_*, data_out_*, cnt_*, fair_cnt, idle; state SHALL be RESET.
REQ-031 Reset asserted mid-transfer SHALL cancel the pending push; the popped word is discarded; no pop occurs while reset=0.
REQ-032 First pop SHALL be possible in the first cycle after the edge that samples reset=1.

Verification
REQ-033 Reset sequence: reset=0 for 3 cycles, both VCs nonempty -> no pops, all outputs 0; reset=1 -> pop_vc0 in the next cycle.
REQ-034 Routing: VC0 head 6'b000001 then 6'b010010 -> push_d0 with 6'b000001 one cycle after its pop; push_d1 with 6'b010010 the cycle after.
REQ-035 Fairness: both VCs continuously nonempty with D0-bound words -> grant pattern VC0, VC0, VC0, VC0, VC1, repeating.
REQ-036 No head-of-line blocking: pause_d0=1, VC0 head to D0, VC1 head 6'b110011 -> pop_vc1 only; push_d1=1 next cycle; pop_vc0 resumes when pause_d0 falls.
REQ-037 Wrap: 256 words to D1 -> cnt_d1 returns to 0 and cnt_d0 stays 0.
REQ-038 Idle: both VCs drain -> idle=1 the cycle after the last push; state IDLE.
